// File: rtl/s1_unidade_controle.sv
// s1_unidade_controle: game-flow FSM for the note-memory game; Moore outputs
// decoded from the state register, plus the per-game memoria/nivel configuration.
module s1_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cfg_memoria,
    input  logic       cfg_nivel,
    input  logic       fimL,
    input  logic       enderecoIgualLimite,
    input  logic       botoesIgualMemoria,
    input  logic       jogadafeita,
    input  logic       timeout,
    input  logic       muda_leds,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraT2,
    output logic       contaT2,
    output logic       mostraJ,
    output logic       mostraB,
    output logic       zeraMemErro,
    output logic       regErro,
    output logic       zeraErro,
    output logic       contaErro,
    output logic       zeraPontos,
    output logic       regPontos,
    output logic       memoria,
    output logic       nivel,
    output logic       pronto,
    output logic       timeout_jogo,
    output logic [4:0] db_estado
);
    typedef enum logic [4:0] {
        INICIAL           = 5'd0,
        PREPARACAO        = 5'd1,
        INICIO_RODADA     = 5'd2,
        PREPARA_NOTA      = 5'd3,
        MOSTRA_NOTA       = 5'd4,
        PREPARA_INTERVALO = 5'd5,
        INTERVALO         = 5'd6,
        AVALIA_NOTA       = 5'd7,
        PREPARA_JOGADA    = 5'd8,
        ESPERA_JOGADA     = 5'd9,
        REGISTRA          = 5'd10,
        COMPARA           = 5'd11,
        GRAVA_ERRO        = 5'd12,
        PROXIMA_JOGADA    = 5'd13,
        ERRO              = 5'd14,
        INCREMENTA_NOTA   = 5'd15,
        INICIO_PONTUACAO  = 5'd16,
        FIM_TIMEOUT       = 5'd17,
        PROXIMA_RODADA    = 5'd18,
        PONTUA_LE         = 5'd19,
        PONTUA_REG        = 5'd20,
        FIM_JOGO          = 5'd21,
        PONTUA_AVANCA     = 5'd22
    } estado_t;

    estado_t estado_q, estado_d;
    logic    memoria_q, nivel_q;

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:           estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:        estado_d = INICIO_RODADA;
            INICIO_RODADA:     estado_d = PREPARA_NOTA;
            PREPARA_NOTA:      estado_d = MOSTRA_NOTA;
            MOSTRA_NOTA:       estado_d = muda_leds ? PREPARA_INTERVALO : MOSTRA_NOTA;
            PREPARA_INTERVALO: estado_d = INTERVALO;
            INTERVALO:         estado_d = muda_leds ? AVALIA_NOTA : INTERVALO;
            AVALIA_NOTA:       estado_d = enderecoIgualLimite ? PREPARA_JOGADA : INCREMENTA_NOTA;
            INCREMENTA_NOTA:   estado_d = PREPARA_NOTA;
            PREPARA_JOGADA:    estado_d = ESPERA_JOGADA;
            // a play in the same cycle as the timeout still counts
            ESPERA_JOGADA:     estado_d = jogadafeita ? REGISTRA : (timeout ? FIM_TIMEOUT : ESPERA_JOGADA);
            REGISTRA:          estado_d = COMPARA;
            COMPARA:           estado_d = !botoesIgualMemoria ? ERRO :
                                          (enderecoIgualLimite ? GRAVA_ERRO : PROXIMA_JOGADA);
            PROXIMA_JOGADA:    estado_d = ESPERA_JOGADA;
            ERRO:              estado_d = ESPERA_JOGADA;
            GRAVA_ERRO:        estado_d = fimL ? INICIO_PONTUACAO : PROXIMA_RODADA;
            PROXIMA_RODADA:    estado_d = INICIO_RODADA;
            INICIO_PONTUACAO:  estado_d = PONTUA_LE;
            PONTUA_LE:         estado_d = PONTUA_REG;
            PONTUA_REG:        estado_d = fimL ? FIM_JOGO : PONTUA_AVANCA;
            PONTUA_AVANCA:     estado_d = PONTUA_LE;
            FIM_JOGO:          estado_d = iniciar ? PREPARACAO : FIM_JOGO;
            FIM_TIMEOUT:       estado_d = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:           estado_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= INICIAL;
            memoria_q <= 1'b0;
            nivel_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == PREPARACAO) begin
                memoria_q <= cfg_memoria;
                nivel_q   <= cfg_nivel;
            end
        end
    end

    assign zeraR        = estado_q inside {PREPARACAO, PREPARA_JOGADA};
    assign registraR    = estado_q == REGISTRA;
    assign zeraL        = estado_q inside {PREPARACAO, INICIO_PONTUACAO};
    assign contaL       = estado_q inside {PROXIMA_RODADA, PONTUA_AVANCA};
    assign zeraE        = estado_q inside {PREPARACAO, INICIO_RODADA, PREPARA_JOGADA};
    assign contaE       = estado_q inside {INCREMENTA_NOTA, PROXIMA_JOGADA};
    assign zeraT        = estado_q inside {PREPARACAO, PREPARA_JOGADA, PROXIMA_JOGADA, ERRO};
    assign contaT       = estado_q == ESPERA_JOGADA;
    assign zeraT2       = estado_q inside {PREPARACAO, PREPARA_NOTA, PREPARA_INTERVALO};
    assign contaT2      = estado_q inside {MOSTRA_NOTA, INTERVALO};
    assign mostraJ      = estado_q == MOSTRA_NOTA;
    assign mostraB      = estado_q inside {ESPERA_JOGADA, REGISTRA};
    assign zeraMemErro  = estado_q == PREPARACAO;
    assign regErro      = estado_q == GRAVA_ERRO;
    assign zeraErro     = estado_q inside {PREPARACAO, INICIO_RODADA};
    assign contaErro    = estado_q == ERRO;
    assign zeraPontos   = estado_q == PREPARACAO;
    assign regPontos    = estado_q == PONTUA_REG;
    assign pronto       = estado_q inside {FIM_JOGO, FIM_TIMEOUT};
    assign timeout_jogo = estado_q == FIM_TIMEOUT;
    assign memoria      = memoria_q;
    assign nivel        = nivel_q;
    assign db_estado    = estado_q;
endmodule

// File: tb/tb_s1_unidade_controle.sv
// tb_s1_unidade_controle: drives the controller against a behavioural datapath
// and checks game-level outcomes plus the per-state output table.
module tb_s1_unidade_controle;
    logic clock = 1'b0;
    logic reset, iniciar, cfg_memoria, cfg_nivel;
    logic fimL, enderecoIgualLimite, botoesIgualMemoria, jogadafeita, timeout, muda_leds;
    logic zeraR, registraR, zeraL, contaL, zeraE, contaE, zeraT, contaT, zeraT2, contaT2;
    logic mostraJ, mostraB, zeraMemErro, regErro, zeraErro, contaErro, zeraPontos, regPontos;
    logic memoria, nivel, pronto, timeout_jogo;
    logic [4:0] db_estado;
    logic [19:0] dut_o;

    localparam logic [19:0] ZR = 20'd1 << 19, RR = 20'd1 << 18, ZL = 20'd1 << 17, CL = 20'd1 << 16;
    localparam logic [19:0] ZE = 20'd1 << 15, CE = 20'd1 << 14, ZT = 20'd1 << 13, CT = 20'd1 << 12;
    localparam logic [19:0] ZT2 = 20'd1 << 11, CT2 = 20'd1 << 10, MJ = 20'd1 << 9, MB = 20'd1 << 8;
    localparam logic [19:0] ZME = 20'd1 << 7, RE = 20'd1 << 6, ZER = 20'd1 << 5, CER = 20'd1 << 4;
    localparam logic [19:0] ZP = 20'd1 << 3, RP = 20'd1 << 2, PR = 20'd1 << 1, TJ = 20'd1;

    s1_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .cfg_memoria(cfg_memoria), .cfg_nivel(cfg_nivel),
        .fimL(fimL), .enderecoIgualLimite(enderecoIgualLimite), .botoesIgualMemoria(botoesIgualMemoria),
        .jogadafeita(jogadafeita), .timeout(timeout), .muda_leds(muda_leds),
        .zeraR(zeraR), .registraR(registraR), .zeraL(zeraL), .contaL(contaL), .zeraE(zeraE), .contaE(contaE),
        .zeraT(zeraT), .contaT(contaT), .zeraT2(zeraT2), .contaT2(contaT2), .mostraJ(mostraJ), .mostraB(mostraB),
        .zeraMemErro(zeraMemErro), .regErro(regErro), .zeraErro(zeraErro), .contaErro(contaErro),
        .zeraPontos(zeraPontos), .regPontos(regPontos), .memoria(memoria), .nivel(nivel),
        .pronto(pronto), .timeout_jogo(timeout_jogo), .db_estado(db_estado)
    );

    assign dut_o = {zeraR, registraR, zeraL, contaL, zeraE, contaE, zeraT, contaT, zeraT2, contaT2,
                    mostraJ, mostraB, zeraMemErro, regErro, zeraErro, contaErro, zeraPontos, regPontos,
                    pronto, timeout_jogo};

    always #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0, bad = 0, cfg_bad = 0;
    int lim = 0, adr = 0, t2 = 0, err = 0, per = 1, wt = 0;
    int notes = 0, round_ok = 0, round_wrong = 0, n_re = 0, n_rp = 0, n_ce = 0, wrong_tot = 0;
    logic [31:0] rp_mask = '0;
    bit auto_play = 0, force_jf = 0, force_to = 0, pend_wrong = 0, err_en = 0, play_ok = 1, prev_mj = 0;
    logic exp_mem = 1'b0, exp_niv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // outputs each state must show, straight from the state list
    function automatic logic [19:0] exp_out(input int s);
        case (s)
            1:       return ZR | ZL | ZE | ZER | ZME | ZP | ZT | ZT2;
            2:       return ZE | ZER;
            3, 5:    return ZT2;
            4:       return MJ | CT2;
            6:       return CT2;
            8:       return ZE | ZT | ZR;
            9:       return CT | MB;
            10:      return RR | MB;
            12:      return RE;
            13:      return CE | ZT;
            14:      return CER | ZT;
            15:      return CE;
            16:      return ZL;
            18, 22:  return CL;
            20:      return RP;
            21:      return PR;
            17:      return PR | TJ;
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        logic [19:0] o;
        int s;
        s = int'(db_estado);
        o = dut_o;
        if (o !== exp_out(s)) bad++;
        if (memoria !== exp_mem || nivel !== exp_niv) cfg_bad++;
        fimL = (lim == (nivel ? 15 : 7));
        enderecoIgualLimite = (adr == lim);
        muda_leds = (t2 >= per);
        timeout = force_to;
        jogadafeita = force_jf;
        if (s == 9 && auto_play) begin
            if (wt > 0) wt--;
            else begin
                jogadafeita = 1'b1;
                wt = $urandom_range(0, 2);
                play_ok = !(pend_wrong || (err_en && round_wrong < 2 && $urandom_range(0, 5) == 0));
                pend_wrong = 0;
            end
        end
        botoesIgualMemoria = play_ok;
        if (o[7]) begin
            round_ok = 0; round_wrong = 0; notes = 0;
            n_re = 0; n_rp = 0; n_ce = 0; wrong_tot = 0; rp_mask = '0;
        end
        if (s == 9 && jogadafeita) begin
            if (play_ok) round_ok++;
            else begin round_wrong++; wrong_tot++; end
        end
        if (o[9] && !prev_mj) notes++;
        prev_mj = o[9];
        if (o[6]) begin
            n_re++;
            check("regErro_errcount", 32'(err), 32'(round_wrong));
            check("round_notes_shown", 32'(notes), 32'(lim + 1));
            check("round_correct_plays", 32'(round_ok), 32'(lim + 1));
            round_ok = 0; round_wrong = 0; notes = 0;
        end
        if (o[2]) begin n_rp++; rp_mask |= 32'd1 << lim; end
        if (o[4]) n_ce++;
        @(posedge clock);
        if (s == 1) begin exp_mem = cfg_memoria; exp_niv = cfg_nivel; end
        lim = o[17] ? 0 : lim + int'(o[16]);
        adr = o[15] ? 0 : adr + int'(o[14]);
        t2  = o[11] ? 0 : t2 + int'(o[10]);
        err = o[5]  ? 0 : err + int'(o[4]);
        @(negedge clock);
    endtask

    task automatic run_to(input int code, input string tag);
        int n = 0;
        while (int'(db_estado) != code && n < 500) begin tick(); n++; end
        check(tag, 32'(db_estado), 32'(code));
    endtask

    task automatic run_game(input logic niv, input bit toggle, input bit first_wrong, input bit errs);
        int n = 0;
        cfg_nivel = niv;
        cfg_memoria = 1'($urandom_range(0, 1));
        per = $urandom_range(1, 3);
        auto_play = 1; pend_wrong = first_wrong; err_en = errs; wt = 0;
        iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
        while (db_estado != 5'd21 && n < 6000) begin
            if (toggle) begin
                cfg_nivel = 1'($urandom_range(0, 1));
                cfg_memoria = 1'($urandom_range(0, 1));
                iniciar = 1'($urandom_range(0, 1));
            end
            tick(); n++;
        end
        iniciar = 1'b0;
        check("game_end_state", 32'(db_estado), 32'd21);
        check("regErro_pulses", 32'(n_re), niv ? 32'd16 : 32'd8);
        check("regPontos_pulses", 32'(n_rp), niv ? 32'd16 : 32'd8);
        check("score_addresses", rp_mask, niv ? 32'hFFFF : 32'hFF);
        check("contaErro_pulses", 32'(n_ce), 32'(wrong_tot));
        check("game_pronto", 32'(pronto), 32'd1);
        check("game_timeout_flag", 32'(timeout_jogo), 32'd0);
        check("nivel_kept", 32'(nivel), 32'(niv));
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; cfg_memoria = 1'b1; cfg_nivel = 1'b1;
        fimL = 0; enderecoIgualLimite = 0; botoesIgualMemoria = 0;
        jogadafeita = 0; timeout = 0; muda_leds = 0;
        @(negedge clock);
        check("reset_state", 32'(db_estado), 32'd0);
        check("reset_outputs", 32'(dut_o), 32'd0);
        check("reset_cfg", 32'({memoria, nivel}), 32'd0);
        reset = 1'b1;
        repeat (3) tick();
        check("idle_without_iniciar", 32'(db_estado), 32'd0);

        // timeout path, then restart from the timeout end state
        auto_play = 0; cfg_nivel = 1'b0; per = 2;
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        run_to(9, "reach_espera");
        repeat (4) tick();
        check("espera_holds", 32'(db_estado), 32'd9);
        force_to = 1; tick(); force_to = 0;
        check("timeout_state", 32'(db_estado), 32'd17);
        check("timeout_pronto", 32'(pronto), 32'd1);
        check("timeout_flag", 32'(timeout_jogo), 32'd1);
        tick(); tick();
        check("timeout_holds", 32'(db_estado), 32'd17);
        iniciar = 1'b1; tick(); iniciar = 1'b0;
        check("restart_state", 32'(db_estado), 32'd1);
        check("restart_clears", 32'(dut_o), 32'(ZR | ZL | ZE | ZER | ZME | ZP | ZT | ZT2));

        // play and timeout together: the play wins
        run_to(9, "reach_espera2");
        play_ok = 1; force_jf = 1; force_to = 1; tick(); force_jf = 0; force_to = 0;
        check("play_beats_timeout", 32'(db_estado), 32'd10);

        // asynchronous reset in the middle of an interval
        run_to(6, "reach_intervalo");
        reset = 1'b0;
        #1;
        check("async_reset_state", 32'(db_estado), 32'd0);
        check("async_reset_outputs", 32'(dut_o), 32'd0);
        check("async_reset_cfg", 32'({memoria, nivel}), 32'd0);
        exp_mem = 1'b0; exp_niv = 1'b0; prev_mj = 0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) tick();
        check("post_reset_idle", 32'(db_estado), 32'd0);

        run_game(1'b0, 0, 0, 0);
        run_game(1'b0, 0, 1, 0);
        run_game(1'b1, 1, 0, 1);

        check("outputs_vs_state_table", 32'(bad), 32'd0);
        check("cfg_latched_only_at_start", 32'(cfg_bad), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/s1_unidade_controle.md
S1_UNIDADE_CONTROLE -- requirements
Module: s1_unidade_controle

Interface
REQ-001 Block SHALL have no parameters.
REQ-002 clock  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 iniciar  in  1  start-game request, level-sensitive.
REQ-005 cfg_memoria, cfg_nivel  in  1 each  sequence-ROM select and level select for the next game.
REQ-006 fimL, enderecoIgualLimite, botoesIgualMemoria, jogadafeita, timeout, muda_leds  in  1 each  datapath condition flags.
REQ-007 zeraR, registraR  out  1 each  play-register clear and load.
REQ-008 zeraL, contaL / zeraE, contaE  out  1 each  limit-counter and address-counter clear and increment.
REQ-009 zeraT, contaT / zeraT2, contaT2  out  1 each  play-timeout timer and LED-period timer clear and count.
REQ-010 mostraJ, mostraB  out  1 each  LEDs show the expected note or the live buttons.
REQ-011 zeraMemErro, regErro, zeraErro, contaErro  out  1 each  error-RAM clear and write, and error-counter clear and increment.
REQ-012 zeraPontos, regPontos  out  1 each  score-register init to 100 and score update.
REQ-013 memoria, nivel  out  1 each  registered configuration driven to the datapath.
REQ-014 pronto, timeout_jogo  out  1 each  game-finished and game-ended-by-timeout flags.
REQ-015 db_estado  out  5  current state code.

Function
REQ-016 Control outputs SHALL be Moore outputs decoded only from the state register; any output not listed for a state SHALL be 0.
REQ-017 State codes and behaviour:
- 0 inicial: wait. iniciar→1.
- 1 preparacao: zeraR, zeraL, zeraE, zeraErro, zeraMemErro, zeraPontos, zeraT, zeraT2; latch cfg_memoria→memoria and cfg_nivel→nivel. →2.
- 2 inicio_rodada: zeraE, zeraErro. →3.
- 3 prepara_nota: zeraT2. →4.
- 4 mostra_nota: mostraJ, contaT2. muda_leds→5.
- 5 prepara_intervalo: zeraT2. →6.
- 6 intervalo: contaT2. muda_leds→7.
- 7 avalia_nota: enderecoIgualLimite→8, else →15.
- 15 incrementa_nota: contaE. →3.
- 8 prepara_jogada: zeraE, zeraT, zeraR. →9.
- 9 espera_jogada: contaT, mostraB. jogadafeita→10; else timeout→17.
- 10 registra: registraR, mostraB. →11.
- 11 compara: if botoesIgualMemoria and enderecoIgualLimite →12; if botoesIgualMemoria only →13; otherwise →14.
- 13 proxima_jogada: contaE, zeraT. →9.
- 14 erro: contaErro, zeraT. →9 (same note is retried).
- 12 grava_erro: regErro. fimL→16, else →18.
- 18 proxima_rodada: contaL. →2.
- 16 inicio_pontuacao: zeraL. →19.
- 19 pontua_le: no outputs; one-cycle wait for the synchronous RAM read. →20.
- 20 pontua_reg: regPontos. fimL→21, else →22.
- 22 pontua_avanca: contaL. →19.
- 21 fim_jogo: pronto. iniciar→1.
- 17 fim_timeout: pronto, timeout_jogo. iniciar→1.
- Codes 23–31: →0 on the next clock.
REQ-018 When jogadafeita and timeout are both 1 in state 9, jogadafeita SHALL win.
REQ-019 iniciar SHALL be ignored in every state except 0, 17 and 21.
REQ-020 memoria and nivel SHALL change only in state 1; cfg_* changes during a game have no effect.
REQ-021 Every state SHALL hold indefinitely while its exit condition is false.
REQ-022 Scoring SHALL visit limit addresses 0 to {nivel,3'b111} inclusive, with exactly one regPontos pulse per address: 8 pulses for nivel=0, 16 pulses for nivel=1.

Reset
REQ-023 reset=0 SHALL force state 0 immediately, regardless of clock, including mid-game.
REQ-024 During reset, every control output, pronto, timeout_jogo, memoria and nivel SHALL be 0, and db_estado SHALL be 0.
REQ-025 The first state change after reset release SHALL occur on the first rising edge with iniciar=1.

Verification
REQ-026 Perfect game: nivel=0, each play matches on the first try → rounds limit 0..7 complete, 8 regErro pulses, 8 regPontos pulses, state 21 with pronto=1.
REQ-027 One wrong play in round 0 (botoesIgualMemoria=0) → exactly one contaErro pulse, state returns to 9, then regErro writes while the error count is 1.
REQ-028 timeout=1 in state 9 with no play → state 17, pronto=1, timeout_jogo=1; later iniciar=1 → state 1 with all clears asserted.
REQ-029 jogadafeita and timeout asserted in the same cycle in state 9 → next state 10, not 17.
REQ-030 reset pulled low while in state 6 → state 0 immediately and all outputs 0; after release, iniciar=0 → stays in 0.
REQ-031 nivel=1 game with cfg_nivel toggled during play → nivel output stays 1 and 16 regPontos pulses occur.
